// File: rtl/prog_pkg.sv
// -----------------------------------------------------------------------------
// prog_pkg
// Constants and types shared by both ends of the UART RAM-programming link
// (this transmitter and the teknofest_ram receiver), so that the magic
// sequence, default timing and state encoding cannot drift apart.
//   PROGRAM_SEQUENCE / PROG_SEQ_LENGTH : "TEKNOFEST" preamble, 9 bytes
//   CPU_CLK_DEFAULT / BAUD_RATE_DEFAULT: default clock and serial rate
//   prog_state_e                       : programmer FSM state encoding
//   prog_seq_byte()                    : i-th preamble byte, 'T' first
//   msb_byte()                         : i-th byte of a word, MSB first
// -----------------------------------------------------------------------------
package prog_pkg;

  localparam int PROG_SEQ_LENGTH = 9;
  localparam logic [8*PROG_SEQ_LENGTH-1:0] PROGRAM_SEQUENCE = "TEKNOFEST";

  localparam int CPU_CLK_DEFAULT   = 20_000_000;
  localparam int BAUD_RATE_DEFAULT = 256_000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LEN,
    ST_FETCH,
    ST_DATA,
    ST_FLUSH
  } prog_state_e;

  // A string literal packs its first character in the most significant byte.
  function automatic logic [7:0] prog_seq_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < PROG_SEQ_LENGTH; i++) begin
      if (idx == 4'(i)) begin
        b = PROGRAM_SEQUENCE[8*(PROG_SEQ_LENGTH-1-i) +: 8];
      end
    end
    return b;
  endfunction

  function automatic logic [7:0] msb_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serialiser with a valid/ready byte interface. Each bit lasts exactly DIV
// clocks. A byte is taken on byte_valid_i && byte_ready_o; its start bit
// appears the following cycle. byte_ready_o returns the cycle after the last
// stop-bit cycle, so back-to-back frames are separated by one idle cycle.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset (line forced idle high)
//   byte_valid_i : byte_data_i holds a byte to send
//   byte_data_i  : byte to send, LSB first on the line
//   byte_ready_o : serialiser idle, can accept a byte
//   tx_o         : serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_byte #(
  parameter int DIV = 78
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       tx_o
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);

  logic             active_q;
  logic [9:0]       shift_q;
  logic [CNT_W-1:0] div_cnt_q;
  logic [3:0]       bit_cnt_q;
  logic             tx_q;

  assign byte_ready_o = ~active_q;
  assign tx_o         = tx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= 1'b0;
      shift_q   <= '1;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
    end else if (!active_q) begin
      if (byte_valid_i) begin
        active_q  <= 1'b1;
        // Frame is {stop, data[7:0], start}; bit 0 goes on the line right away.
        shift_q   <= {1'b1, byte_data_i, 1'b0};
        div_cnt_q <= '0;
        bit_cnt_q <= '0;
        tx_q      <= 1'b0;
      end
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_q <= '0;
      if (bit_cnt_q == 4'd9) begin
        active_q <= 1'b0;
        tx_q     <= 1'b1;
      end else begin
        bit_cnt_q <= bit_cnt_q + 4'd1;
        shift_q   <= {1'b1, shift_q[9:1]};
        tx_q      <= shift_q[1];
      end
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_prog_tx.sv
// -----------------------------------------------------------------------------
// uart_prog_tx
// Transmitting end of the UART RAM-programming protocol. On start it sends
// "TEKNOFEST", a 32-bit word count (MSB byte first) and then that many 32-bit
// words read from a synchronous memory port starting at BASE_ADDR (each word
// MSB byte first). Total bytes per transfer: 13 + 4*N.
//   clk_i        : system clock
//   rst_ni       : asynchronous active-low reset
//   start_i      : one-cycle start request, honoured only when idle
//   word_count_i : number of words, latched with start_i
//   rd_en_o      : memory read enable (one cycle per word)
//   rd_addr_o    : memory word address, wraps modulo 2^ADDR_WIDTH
//   rd_data_i    : memory data, valid the cycle after rd_en_o
//   tx_o         : UART serial output, idle high
//   busy_o       : transfer in progress
//   done_o       : one-cycle pulse once the last stop bit has completed
// -----------------------------------------------------------------------------
module uart_prog_tx
  import prog_pkg::*;
#(
  parameter int CPU_CLK    = CPU_CLK_DEFAULT,
  parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int ADDR_WIDTH = 17,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [31:0]           word_count_i,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [31:0]           rd_data_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int DIV = CPU_CLK / BAUD_RATE;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  prog_state_e           state_q;
  logic [3:0]            byte_idx_q;
  logic [31:0]           count_q;
  logic [31:0]           sent_q;
  logic [31:0]           sent_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           word_q;
  logic                  rd_en_q;
  logic                  fetch_wait_q;
  logic                  busy_q;
  logic                  done_q;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  byte_fire;

  assign rd_en_o   = rd_en_q;
  assign rd_addr_o = addr_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign byte_fire = byte_valid & byte_ready;
  assign sent_d    = sent_q + 32'd1;

  always_comb begin
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    case (state_q)
      ST_HDR: begin
        byte_valid = 1'b1;
        byte_data  = prog_seq_byte(byte_idx_q);
      end
      ST_LEN: begin
        byte_valid = 1'b1;
        byte_data  = msb_byte(count_q, byte_idx_q[1:0]);
      end
      ST_DATA: begin
        byte_valid = 1'b1;
        byte_data  = msb_byte(word_q, byte_idx_q[1:0]);
      end
      default: ;
    endcase
  end

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .tx_o         (tx_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      byte_idx_q   <= '0;
      count_q      <= '0;
      sent_q       <= '0;
      addr_q       <= BASE;
      word_q       <= '0;
      rd_en_q      <= 1'b0;
      fetch_wait_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            count_q    <= word_count_i;
            sent_q     <= '0;
            byte_idx_q <= '0;
            addr_q     <= BASE;
            busy_q     <= 1'b1;
            state_q    <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (byte_fire) begin
            if (byte_idx_q == 4'(PROG_SEQ_LENGTH - 1)) begin
              byte_idx_q <= '0;
              state_q    <= ST_LEN;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end
        ST_LEN: begin
          if (byte_fire) begin
            if (byte_idx_q == 4'd3) begin
              byte_idx_q <= '0;
              if (count_q == 32'd0) begin
                state_q <= ST_FLUSH;
              end else begin
                // Read enable rises together with entry into FETCH.
                rd_en_q      <= 1'b1;
                fetch_wait_q <= 1'b0;
                state_q      <= ST_FETCH;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end
        ST_FETCH: begin
          rd_en_q <= 1'b0;
          // First FETCH cycle issues the read, second captures the data.
          if (fetch_wait_q) begin
            word_q       <= rd_data_i;
            fetch_wait_q <= 1'b0;
            state_q      <= ST_DATA;
          end else begin
            fetch_wait_q <= 1'b1;
          end
        end
        ST_DATA: begin
          if (byte_fire) begin
            if (byte_idx_q == 4'd3) begin
              byte_idx_q <= '0;
              addr_q     <= addr_q + 1'b1;
              sent_q     <= sent_d;
              if (sent_d == count_q) begin
                state_q <= ST_FLUSH;
              end else begin
                rd_en_q      <= 1'b1;
                fetch_wait_q <= 1'b0;
                state_q      <= ST_FETCH;
              end
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
            end
          end
        end
        ST_FLUSH: begin
          // The last byte was accepted on entry, so ready means its stop bit ended.
          if (byte_ready) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_prog_tx
// Two instances: dut_m at default timing (DIV=78, BASE_ADDR=0) and dut_w with
// a fast baud (DIV=8) and BASE_ADDR=0x1FFFF for the address-wrap case. A serial
// monitor decodes frames from the selected line and checks them against a
// queue of expected bytes pushed when each transfer is started.
// -----------------------------------------------------------------------------
module tb_uart_prog_tx;

  localparam int DIV_M = 78;
  localparam int DIV_W = 8;
  localparam int AW    = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start_m, start_w;
  logic [31:0]   cnt_m, cnt_w;
  logic          rd_en_m, rd_en_w;
  logic [AW-1:0] rd_addr_m, rd_addr_w;
  logic [31:0]   rd_data_m, rd_data_w;
  logic          tx_m, tx_w, busy_m, busy_w, done_m, done_w;

  uart_prog_tx #(
    .CPU_CLK(20_000_000), .BAUD_RATE(256_000), .ADDR_WIDTH(AW), .BASE_ADDR(0)
  ) dut_m (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_m), .word_count_i(cnt_m),
    .rd_en_o(rd_en_m), .rd_addr_o(rd_addr_m), .rd_data_i(rd_data_m),
    .tx_o(tx_m), .busy_o(busy_m), .done_o(done_m)
  );

  uart_prog_tx #(
    .CPU_CLK(20_000_000), .BAUD_RATE(2_500_000), .ADDR_WIDTH(AW), .BASE_ADDR(131071)
  ) dut_w (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_w), .word_count_i(cnt_w),
    .rd_en_o(rd_en_w), .rd_addr_o(rd_addr_w), .rd_data_i(rd_data_w),
    .tx_o(tx_w), .busy_o(busy_w), .done_o(done_w)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [7:0] exp_q[$];
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Source memory contents
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [31:0] w;
    case (a)
      17'h00000: w = 32'h0000_0013;
      17'h00001: w = 32'hDEAD_BEEF;
      17'h1FFFF: w = 32'hCAFE_F00D;
      default:   w = 32'h5A00_0000 | {15'h0, a};
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    if (rd_en_m) rd_data_m <= mem_word(rd_addr_m);
    if (rd_en_w) rd_data_w <= mem_word(rd_addr_w);
  end

  int rd_cnt_m   = 0;
  int done_cnt_m = 0;
  int done_cnt_w = 0;
  logic [AW-1:0] addr_log_w[$];

  always @(negedge clk) begin
    if (rd_en_m === 1'b1) rd_cnt_m++;
    if (done_m === 1'b1) done_cnt_m++;
    if (done_w === 1'b1) done_cnt_w++;
    if (rd_en_w === 1'b1) addr_log_w.push_back(rd_addr_w);
  end

  // Serial monitor
  logic   sel_w         = 1'b0;
  logic   mon_ignore    = 1'b0;
  logic   first_in_xfer = 1'b0;
  int     xfer_frames   = 0;
  longint last_start    = 0;
  wire    mon_tx = sel_w ? tx_w : tx_m;

  initial begin : monitor
    logic samp [0:10*DIV_M-1];
    int div;
    bit aborted;
    longint t0;
    logic [7:0] got, expb;
    int low_run, exp_low, tz;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mon_tx === 1'b0) begin
        div = sel_w ? DIV_W : DIV_M;
        aborted = 0;
        t0 = cyc;
        samp[0] = 1'b0;
        for (int k = 1; k < 10*div; k++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1;
            break;
          end
          samp[k] = mon_tx;
        end
        if (!aborted) begin
          xfer_frames++;
          if (!mon_ignore) begin
            for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*div + div/2];
            if (exp_q.size() == 0) begin
              tests_run++; tests_failed++;
              $display("FAIL scoreboard_extra: got byte %02h, required no byte", got);
            end else begin
              expb = exp_q.pop_front();
              $display("[TB] frame %0d: byte %02h expected %02h at cycle %0d", xfer_frames, got, expb, t0);
              tests_run++;
              if (got !== expb) begin
                tests_failed++;
                $display("FAIL frame_byte: got %02h, required %02h", got, expb);
              end
              tests_run++;
              if (samp[9*div + div/2] !== 1'b1) begin
                tests_failed++;
                $display("FAIL stop_bit: got %b, required 1", samp[9*div + div/2]);
              end
              // Start bit plus trailing zero data bits form one low run.
              tz = 0;
              while (tz < 8 && expb[tz] == 1'b0) tz++;
              exp_low = div * (1 + tz);
              low_run = 0;
              while (low_run < 10*div && samp[low_run] === 1'b0) low_run++;
              tests_run++;
              if (low_run != exp_low) begin
                tests_failed++;
                $display("FAIL bit_timing: low run %0d cycles, required %0d", low_run, exp_low);
              end
              if (!first_in_xfer) begin
                tests_run++;
                if (t0 - last_start != longint'(10*div + 1)) begin
                  tests_failed++;
                  $display("FAIL frame_gap: start spacing %0d, required %0d", t0 - last_start, 10*div + 1);
                end
              end
            end
          end
          first_in_xfer = 1'b0;
          last_start = t0;
        end
      end
    end
  end

  task automatic push_expected(input logic [31:0] n, input logic [AW-1:0] base);
    logic [7:0] magic [9];
    logic [AW-1:0] a;
    logic [31:0] w;
    magic = '{8'h54, 8'h45, 8'h4B, 8'h4E, 8'h4F, 8'h46, 8'h45, 8'h53, 8'h54};
    for (int i = 0; i < 9; i++) exp_q.push_back(magic[i]);
    exp_q.push_back(n[31:24]); exp_q.push_back(n[23:16]);
    exp_q.push_back(n[15:8]);  exp_q.push_back(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      a = base + AW'(i);
      w = mem_word(a);
      exp_q.push_back(w[31:24]); exp_q.push_back(w[23:16]);
      exp_q.push_back(w[15:8]);  exp_q.push_back(w[7:0]);
    end
  endtask

  task automatic pulse_start(input bit use_w, input logic [31:0] n);
    @(negedge clk);
    xfer_frames = 0;
    first_in_xfer = 1'b1;
    if (use_w) begin start_w = 1'b1; cnt_w = n; end
    else       begin start_m = 1'b1; cnt_m = n; end
    @(negedge clk);
    start_w = 1'b0;
    start_m = 1'b0;
  endtask

  task automatic wait_done(input bit use_w, input int budget, output bit seen);
    seen = 0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if ((use_w ? done_w : done_m) === 1'b1) seen = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_m = 1'b0; start_w = 1'b0; cnt_m = '0; cnt_w = '0;
    repeat (3) @(negedge clk);
    tests_run++; if (tx_m !== 1'b1) begin tests_failed++; $display("FAIL reset_tx: got %b, required 1", tx_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy_m); end
    tests_run++; if (done_m !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b, required 0", done_m); end
    tests_run++; if (rd_en_m !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_en: got %b, required 0", rd_en_m); end
    tests_run++; if (rd_addr_m !== 17'h00000) begin tests_failed++; $display("FAIL reset_addr_m: got %h, required 00000", rd_addr_m); end
    tests_run++; if (rd_addr_w !== 17'h1FFFF) begin tests_failed++; $display("FAIL reset_addr_w: got %h, required 1ffff", rd_addr_w); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (busy_m !== 1'b0 || tx_m !== 1'b1) begin tests_failed++; $display("FAIL idle_after_reset: busy %b tx %b, required 0 1", busy_m, tx_m); end
  endtask

  task automatic test_two_words();
    bit seen;
    done_cnt_m = 0; rd_cnt_m = 0;
    push_expected(32'd2, 17'h0);
    pulse_start(1'b0, 32'd2);
    tests_run++; if (busy_m !== 1'b1) begin tests_failed++; $display("FAIL busy_after_start: got %b, required 1", busy_m); end
    wait_done(1'b0, 25000, seen);
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL two_words_done: timeout, required done pulse"); end
    tests_run++; if (xfer_frames != 21) begin tests_failed++; $display("FAIL two_words_frames: got %0d, required 21", xfer_frames); end
    repeat (5) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL two_words_missing: %0d bytes left, required 0", exp_q.size()); end
    tests_run++; if (done_cnt_m != 1) begin tests_failed++; $display("FAIL two_words_done_cnt: got %0d, required 1", done_cnt_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL two_words_busy: got %b, required 0", busy_m); end
    tests_run++; if (rd_cnt_m != 2) begin tests_failed++; $display("FAIL two_words_reads: got %0d, required 2", rd_cnt_m); end
  endtask

  task automatic test_zero_count();
    bit seen;
    done_cnt_m = 0; rd_cnt_m = 0;
    push_expected(32'd0, 17'h0);
    pulse_start(1'b0, 32'd0);
    wait_done(1'b0, 15000, seen);
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL zero_done: timeout, required done pulse"); end
    tests_run++; if (xfer_frames != 13) begin tests_failed++; $display("FAIL zero_frames: got %0d, required 13", xfer_frames); end
    repeat (5) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL zero_missing: %0d bytes left, required 0", exp_q.size()); end
    tests_run++; if (rd_cnt_m != 0) begin tests_failed++; $display("FAIL zero_reads: got %0d, required 0", rd_cnt_m); end
    tests_run++; if (done_cnt_m != 1 || busy_m !== 1'b0) begin tests_failed++; $display("FAIL zero_end: done_cnt %0d busy %b, required 1 0", done_cnt_m, busy_m); end
  endtask

  task automatic test_start_ignored();
    bit seen;
    done_cnt_m = 0; rd_cnt_m = 0;
    push_expected(32'd2, 17'h0);
    pulse_start(1'b0, 32'd2);
    seen = 0;
    for (int c = 0; c < 25000 && !seen; c++) begin
      @(negedge clk);
      if (done_m === 1'b1) seen = 1;
      start_m = (c < 15000) && ((c % 40) < 12);
      cnt_m = 32'd5;
    end
    start_m = 1'b0;
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL ignore_done: timeout, required done pulse"); end
    tests_run++; if (xfer_frames != 21) begin tests_failed++; $display("FAIL ignore_frames: got %0d, required 21", xfer_frames); end
    repeat (50) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL ignore_missing: %0d bytes left, required 0", exp_q.size()); end
    tests_run++; if (rd_cnt_m != 2 || done_cnt_m != 1) begin tests_failed++; $display("FAIL ignore_counts: reads %0d done %0d, required 2 1", rd_cnt_m, done_cnt_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL ignore_busy: got %b, required 0", busy_m); end
  endtask

  task automatic test_reset_mid_data();
    bit seen, ok, ok2;
    mon_ignore = 1'b1;
    pulse_start(1'b0, 32'd2);
    ok = 0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge clk);
      if (xfer_frames >= 14) ok = 1;
    end
    ok2 = 0;
    for (int c = 0; c < 2000 && ok && !ok2; c++) begin
      @(negedge clk);
      if (tx_m === 1'b0) ok2 = 1;
    end
    tests_run++; if (!ok || !ok2) begin tests_failed++; $display("FAIL mid_reach_data: frames %0d low %b, required 14 1", xfer_frames, ok2); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if (tx_m !== 1'b1) begin tests_failed++; $display("FAIL mid_reset_tx: got %b, required 1", tx_m); end
    tests_run++; if (busy_m !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_busy: got %b, required 0", busy_m); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    mon_ignore = 1'b0;
    @(negedge clk);
    done_cnt_m = 0; rd_cnt_m = 0;
    push_expected(32'd1, 17'h0);
    pulse_start(1'b0, 32'd1);
    wait_done(1'b0, 20000, seen);
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL restart_done: timeout, required done pulse"); end
    tests_run++; if (xfer_frames != 17) begin tests_failed++; $display("FAIL restart_frames: got %0d, required 17", xfer_frames); end
    repeat (5) @(negedge clk);
    tests_run++; if (exp_q.size() != 0 || rd_cnt_m != 1) begin tests_failed++; $display("FAIL restart_end: %0d bytes left, reads %0d, required 0 1", exp_q.size(), rd_cnt_m); end
  endtask

  task automatic test_addr_wrap();
    bit seen;
    sel_w = 1'b1;
    addr_log_w.delete();
    done_cnt_w = 0;
    push_expected(32'd2, 17'h1FFFF);
    pulse_start(1'b1, 32'd2);
    wait_done(1'b1, 4000, seen);
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL wrap_done: timeout, required done pulse"); end
    tests_run++; if (xfer_frames != 21) begin tests_failed++; $display("FAIL wrap_frames: got %0d, required 21", xfer_frames); end
    repeat (5) @(negedge clk);
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wrap_missing: %0d bytes left, required 0", exp_q.size()); end
    tests_run++;
    if (addr_log_w.size() != 2 || addr_log_w[0] !== 17'h1FFFF || addr_log_w[1] !== 17'h00000) begin
      tests_failed++;
      $display("FAIL wrap_addrs: %0d reads, required 2 reads at 1ffff then 00000", addr_log_w.size());
    end
    tests_run++; if (done_cnt_w != 1 || busy_w !== 1'b0) begin tests_failed++; $display("FAIL wrap_end: done_cnt %0d busy %b, required 1 0", done_cnt_w, busy_w); end
    sel_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_zero_count();
    test_start_ignored();
    test_reset_mid_data();
    test_addr_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_prog_tx.md
Name: uart_prog_tx

Overview:
- Hardware programmer: the transmitting end of the UART RAM-programming protocol used by teknofest_ram.
- Reads a block of 32-bit words from a local synchronous memory port.
- Sends magic sequence "TEKNOFEST", then a 4-byte word count, then each word, over 8N1 UART.
- Used on a host/loader board, or looped back in simulation to program a target core's RAM.

Parameters:
- CPU_CLK, 20_000_000, system clock frequency in Hz.
- BAUD_RATE, 256000, serial bit rate.
- ADDR_WIDTH, 17, word-address width of the source memory read port.
- BASE_ADDR, 0, first word address read.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- start_i  input  1  one-cycle request to begin a transfer.
- word_count_i  input  32  number of words to send; sampled when start_i is accepted.
- rd_en_o  output  1  source memory read enable.
- rd_addr_o  output  ADDR_WIDTH  source memory word address.
- rd_data_i  input  32  read data, valid the cycle after rd_en_o.
- tx_o  output  1  UART serial output, idle high.
- busy_o  output  1  high from start acceptance until done.
- done_o  output  1  one-cycle pulse when the transfer completes.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni.
- Reset values: tx_o=1, busy_o=0, done_o=0, rd_en_o=0, rd_addr_o=BASE_ADDR. FSM goes to IDLE and all counters clear.
- Reset mid-transfer: tx_o goes high immediately (asynchronous). No partial frame resumes.
- Bit timing: DIV = CPU_CLK/BAUD_RATE, truncated; 78 at defaults. Each bit lasts exactly DIV cycles.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. One frame is 10*DIV cycles.
- Byte handshake (internal): the shifter asserts byte_ready when idle. A byte is accepted on byte_valid && byte_ready. The start bit begins the following cycle. byte_ready reasserts the cycle after the stop bit's last cycle, so at most 1 idle cycle separates consecutive frames.
- Start: start_i is accepted only in IDLE. On acceptance, latch word_count_i and set busy_o the next cycle. start_i while busy is ignored.
- Byte order: the magic sequence goes first, 'T' first. Length and each data word are sent MSB byte first (bits 31:24 first).
- FSM states:
  - IDLE: on start_i, clear counters and go to HDR.
  - HDR: send the 9 magic bytes 54 45 4B 4E 4F 46 45 53 54. After the 9th is accepted, go to LEN.
  - LEN: send the 4 length bytes MSB first. After the 4th is accepted: if count==0 go to FLUSH, else go to FETCH.
  - FETCH: assert rd_en_o for exactly 1 cycle with rd_addr_o = current address. Capture rd_data_i into the word register the following cycle, then go to DATA.
  - DATA: send the 4 word bytes. After the 4th is accepted, increment the address and word counter. If words sent == count go to FLUSH, else go to FETCH.
  - FLUSH: wait until the shifter is idle (the last stop bit is complete), then pulse done_o for 1 cycle, clear busy_o, and go to IDLE.
- Total bytes per transfer: 13 + 4*N.
- Address arithmetic: the address increments modulo 2^ADDR_WIDTH and wraps silently. The word counter is 32 bits, so the count is never truncated.
- word_count_i = 0 is legal: header plus length 00 00 00 00, then done. The receiver finishes immediately in this case.
- Long transfers: there is no per-word timeout. The receiver's 1,000,000-cycle break timeout only applies while the magic sequence is arriving, and inter-byte gaps here are at most 3 cycles.
- rd_en_o is never asserted outside FETCH.

Decomposition:
- Shared package prog_pkg:
  - PROGRAM_SEQUENCE "TEKNOFEST" and PROG_SEQ_LENGTH 9.
  - Default CPU_CLK and BAUD_RATE.
  - FSM state encoding.
  - Reuse these from the receiver side so both ends stay consistent.
- One sub-module: uart_tx_byte.
  - Holds the DIV counter, bit counter and 10-bit shift register.
  - byte_valid/byte_ready/byte_data interface.
  - tx_o output.

Test Plan:
- N=2, memory[0]=0x00000013, memory[1]=0xDEADBEEF, start -> serial decodes to 54 45 4B 4E 4F 46 45 53 54 00 00 00 02 00 00 00 13 DE AD BE EF. done_o pulses once after 21 frames; each bit measures 78 cycles.
- word_count_i=0 -> 13 bytes, the last four 00 00 00 00. rd_en_o is never asserted; done_o pulses and busy_o falls.
- Loopback into teknofest_ram's receiver with N=3 words -> RAM words 0..2 match the source. The receiver's system_reset_o pulses low.
- start_i held/pulsed repeatedly during a transfer -> ignored; byte stream is identical to a single-start run.
- rst_ni asserted mid-DATA byte -> tx_o high in the same cycle and busy_o=0. A new start afterwards sends a complete, correct stream.
- BASE_ADDR=2^17-1, N=2 -> reads addresses 0x1FFFF then 0x00000 (wrap); the length field reads 00 00 00 02.
